// File: rtl/data_bus_bridge_if.sv
// SRAM-like bus between the data bridge (master) and the memory system (slave).
// The request side carries req/addr_ok, and the data side carries data_ok/rdata.
interface data_bus_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
);
  logic                  bus_req;
  logic                  bus_wr;
  logic [SEL_WIDTH-1:0]  bus_wstrb;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/data_bus_bridge.sv
// Data-RAM bridge: turns the one-cycle MEM-stage access into a req/addr_ok/
// data_ok bus transaction, stalls the pipeline while it is outstanding, and
// abandons the result on a flush without ever withdrawing a raised request.
module data_bus_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_en,
  input  logic [SEL_WIDTH-1:0]  ram_write_en,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic                  addr_error,
  input  logic                  flush,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] ram_read_data,
  data_bus_bridge_if.master     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  cancel_q, cancel_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_wr_q, bus_wr_d;
  logic [SEL_WIDTH-1:0]  bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  go_s;
  logic                  stall_s;
  logic                  addr_lsb_unused;

  // The byte offset is dropped: the bus always sees word addresses.
  assign addr_lsb_unused = ^ram_addr[1:0];

  assign go_s = ram_en & ~addr_error & ~flush;

  // Next-state, transaction registers and cancel tracking.
  always_comb begin
    state_d     = state_q;
    cancel_d    = cancel_q;
    bus_wr_d    = bus_wr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          state_d     = ST_REQ;
          bus_addr_d  = {ram_addr[ADDR_WIDTH-1:2], 2'b00};
          bus_wstrb_d = ram_write_en;
          bus_wr_d    = |ram_write_en;
          bus_wdata_d = ram_write_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A flush only marks the transaction; the request must stay up.
        if (flush) begin
          cancel_d = 1'b1;
        end else begin
          cancel_d = cancel_q;
        end
        if (bus.bus_addr_ok) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.bus_data_ok) begin
          if (!bus_wr_q && !cancel_q) begin
            rdata_d = bus.bus_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          // An abandoned access skips DONE so the next request goes out at once.
          if (cancel_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
          cancel_d = 1'b0;
        end else begin
          if (flush) begin
            cancel_d = 1'b1;
          end else begin
            cancel_d = cancel_q;
          end
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        // Inputs still belong to the finished instruction: never re-issue.
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        cancel_d = 1'b0;
      end
    endcase
    bus_req_d = (state_d == ST_REQ);
  end

  // Pipeline stall request for the current cycle.
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      ST_IDLE: stall_s = go_s;
      ST_REQ, ST_WAIT: begin
        if (cancel_q) begin
          stall_s = ram_en & ~addr_error;
        end else begin
          stall_s = ~flush;
        end
      end
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // State and bus-side registers, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cancel_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_wstrb_q <= {SEL_WIDTH{1'b0}};
      bus_addr_q  <= {ADDR_WIDTH{1'b0}};
      bus_wdata_q <= {DATA_WIDTH{1'b0}};
      rdata_q     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      bus_req_q   <= bus_req_d;
      bus_wr_q    <= bus_wr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign stall_req     = stall_s;
  assign ram_read_data = rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_wr    = bus_wr_q;
  assign bus.bus_wstrb = bus_wstrb_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_data_bus_bridge;
  logic        clk;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        addr_error;
  logic        flush;
  logic        stall_req;
  logic [31:0] ram_read_data;

  int n_chk;
  int n_fail;
  int n_txn;
  int txn_base;

  data_bus_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) bus_if ();

  data_bus_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_en         (ram_en),
    .ram_write_en   (ram_write_en),
    .ram_addr       (ram_addr),
    .ram_write_data (ram_write_data),
    .addr_error     (addr_error),
    .flush          (flush),
    .stall_req      (stall_req),
    .ram_read_data  (ram_read_data),
    .bus            (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted address phases.
  always @(posedge clk) begin
    if (rst && bus_if.bus_req && bus_if.bus_addr_ok) n_txn <= n_txn + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ram_en = 1'b0; ram_write_en = 4'h0; ram_addr = 32'h0; ram_write_data = 32'h0;
    addr_error = 1'b0; flush = 1'b0;
    bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus_if.bus_req); end
    n_chk++; if ({bus_if.bus_wr, bus_if.bus_wstrb, bus_if.bus_addr, bus_if.bus_wdata} !== 69'h0) begin n_fail++; $display("FAIL reset_bus got wr=%b strb=%h addr=%h wdata=%h exp 0", bus_if.bus_wr, bus_if.bus_wstrb, bus_if.bus_addr, bus_if.bus_wdata); end
    n_chk++; if (ram_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", ram_read_data); end
    n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_req); end
    cyc(); rst = 1'b1;
  endtask

  task automatic test_read();
    cyc(); ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h0000_1006;
    @(negedge clk);
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL read_stall_T got %b exp 1", stall_req); end
    n_chk++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL read_req_T got %b exp 0", bus_if.bus_req); end
    cyc(); bus_if.bus_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (bus_if.bus_req !== 1'b1) begin n_fail++; $display("FAIL read_req_T1 got %b exp 1", bus_if.bus_req); end
    n_chk++; if (bus_if.bus_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL read_addr got %h exp 00001004", bus_if.bus_addr); end
    n_chk++; if (bus_if.bus_wr !== 1'b0) begin n_fail++; $display("FAIL read_wr got %b exp 0", bus_if.bus_wr); end
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL read_stall_T1 got %b exp 1", stall_req); end
    cyc(); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL read_req_T2 got %b exp 0", bus_if.bus_req); end
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL read_stall_T2 got %b exp 1", stall_req); end
    cyc(); bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'h0;
    @(negedge clk);
    n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL read_stall_T3 got %b exp 0", stall_req); end
    n_chk++; if (ram_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_data got %h exp deadbeef", ram_read_data); end
    cyc(); idle_inputs();
    @(negedge clk);
    n_chk++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL read_no_reissue got %b exp 0", bus_if.bus_req); end
  endtask

  task automatic test_store();
    cyc(); ram_en = 1'b1; ram_write_en = 4'b0100; ram_addr = 32'h0000_2002; ram_write_data = 32'h00AB_0000;
    @(negedge clk);
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL store_stall_T got %b exp 1", stall_req); end
    for (int i = 0; i < 3; i++) begin
      cyc(); bus_if.bus_addr_ok = (i == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      n_chk++; if (bus_if.bus_req !== 1'b1) begin n_fail++; $display("FAIL store_req[%0d] got %b exp 1", i, bus_if.bus_req); end
      n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL store_stall_req[%0d] got %b exp 1", i, stall_req); end
      n_chk++; if ({bus_if.bus_wr, bus_if.bus_wstrb, bus_if.bus_addr, bus_if.bus_wdata} !== {1'b1, 4'b0100, 32'h0000_2000, 32'h00AB_0000}) begin
        n_fail++; $display("FAIL store_bus[%0d] got wr=%b strb=%h addr=%h wdata=%h exp 1/4/00002000/00ab0000", i, bus_if.bus_wr, bus_if.bus_wstrb, bus_if.bus_addr, bus_if.bus_wdata);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = (i == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      n_chk++; if ({bus_if.bus_req, stall_req} !== 2'b01) begin n_fail++; $display("FAIL store_wait[%0d] got req/stall=%b%b exp 01", i, bus_if.bus_req, stall_req); end
    end
    cyc(); bus_if.bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL store_done_stall got %b exp 0", stall_req); end
    n_chk++; if (ram_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_rdata got %h exp deadbeef", ram_read_data); end
    cyc(); idle_inputs();
  endtask

  task automatic test_flush_wait();
    cyc(); ram_en = 1'b1; ram_addr = 32'h0000_3000;
    cyc(); bus_if.bus_addr_ok = 1'b1;
    cyc(); bus_if.bus_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL fw_flush_stall got %b exp 0", stall_req); end
    cyc(); flush = 1'b0; ram_en = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    @(negedge clk);
    n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL fw_cancel_stall got %b exp 0", stall_req); end
    // Next cycle is IDLE (not DONE): a fresh load must stall immediately.
    cyc(); bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'h0; ram_en = 1'b1; ram_addr = 32'h0000_0040;
    @(negedge clk);
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL fw_no_done got %b exp 1", stall_req); end
    n_chk++; if (ram_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fw_rdata_kept got %h exp deadbeef", ram_read_data); end
    cyc(); bus_if.bus_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h0000_0040}) begin n_fail++; $display("FAIL fw_next_req got req=%b addr=%h exp 1/00000040", bus_if.bus_req, bus_if.bus_addr); end
    cyc(); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
    cyc(); bus_if.bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (ram_read_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL fw_next_rdata got %h exp cafef00d", ram_read_data); end
    cyc(); idle_inputs();
  endtask

  task automatic test_flush_req();
    txn_base = n_txn;
    cyc(); ram_en = 1'b1; ram_addr = 32'h0000_0050;
    cyc(); flush = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus_if.bus_req, stall_req} !== 2'b10) begin n_fail++; $display("FAIL fr_flush got req/stall=%b%b exp 10", bus_if.bus_req, stall_req); end
    for (int i = 0; i < 4; i++) begin
      cyc(); flush = 1'b0; ram_addr = 32'h0000_0060; bus_if.bus_addr_ok = (i == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      n_chk++; if ({bus_if.bus_req, stall_req} !== 2'b11) begin n_fail++; $display("FAIL fr_hold[%0d] got req/stall=%b%b exp 11", i, bus_if.bus_req, stall_req); end
    end
    cyc(); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hBADB_AD00;
    @(negedge clk);
    n_chk++; if ({bus_if.bus_req, stall_req} !== 2'b01) begin n_fail++; $display("FAIL fr_drain got req/stall=%b%b exp 01", bus_if.bus_req, stall_req); end
    cyc(); bus_if.bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL fr_new_stall got %b exp 1", stall_req); end
    n_chk++; if (ram_read_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL fr_rdata_kept got %h exp cafef00d", ram_read_data); end
    cyc(); bus_if.bus_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h0000_0060}) begin n_fail++; $display("FAIL fr_new_req got req=%b addr=%h exp 1/00000060", bus_if.bus_req, bus_if.bus_addr); end
    cyc(); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h1111_2222;
    cyc(); bus_if.bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if ({stall_req, ram_read_data} !== {1'b0, 32'h1111_2222}) begin n_fail++; $display("FAIL fr_new_done got stall=%b rdata=%h exp 0/11112222", stall_req, ram_read_data); end
    cyc(); idle_inputs();
    n_chk++; if (n_txn - txn_base !== 2) begin n_fail++; $display("FAIL fr_txn_count got %0d exp 2", n_txn - txn_base); end
  endtask

  task automatic test_addr_error();
    cyc(); ram_en = 1'b1; ram_write_en = 4'hF; ram_addr = 32'h0000_0071; ram_write_data = 32'h5555_AAAA; addr_error = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if ({bus_if.bus_req, stall_req} !== 2'b00) begin n_fail++; $display("FAIL aerr[%0d] got req/stall=%b%b exp 00", i, bus_if.bus_req, stall_req); end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    cyc(); ram_en = 1'b1; ram_addr = 32'h0000_0010;
    cyc(); bus_if.bus_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h0000_0010}) begin n_fail++; $display("FAIL b2b_req0 got req=%b addr=%h exp 1/00000010", bus_if.bus_req, bus_if.bus_addr); end
    cyc(); bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h0000_00A0;
    cyc(); bus_if.bus_data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if ({stall_req, ram_read_data} !== {1'b0, 32'h0000_00A0}) begin n_fail++; $display("FAIL b2b_done0 got stall=%b rdata=%h exp 0/000000a0", stall_req, ram_read_data); end
    cyc(); ram_addr = 32'h0000_0014;
    @(negedge clk);
    n_chk++; if ({bus_if.bus_req, stall_req} !== 2'b01) begin n_fail++; $display("FAIL b2b_no_dup got req/stall=%b%b exp 01", bus_if.bus_req, stall_req); end
    cyc(); bus_if.bus_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h0000_0014}) begin n_fail++; $display("FAIL b2b_req1 got req=%b addr=%h exp 1/00000014", bus_if.bus_req, bus_if.bus_addr); end
    cyc(); bus_if.bus_addr_ok = 1'b0; ram_en = 1'b0;
    @(negedge clk);
    n_chk++; if (bus_if.bus_addr !== 32'h0000_0014) begin n_fail++; $display("FAIL b2b_wait_addr got %h exp 00000014", bus_if.bus_addr); end
    #1 rst = 1'b0;
    #1;
    n_chk++; if ({bus_if.bus_req, bus_if.bus_wr, bus_if.bus_wstrb, bus_if.bus_addr, bus_if.bus_wdata} !== 70'h0) begin n_fail++; $display("FAIL rst_async_bus got req=%b addr=%h exp 0", bus_if.bus_req, bus_if.bus_addr); end
    n_chk++; if ({stall_req, ram_read_data} !== 33'h0) begin n_fail++; $display("FAIL rst_async_out got stall=%b rdata=%h exp 0/0", stall_req, ram_read_data); end
    cyc(); rst = 1'b1;
    @(negedge clk);
    n_chk++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_release_req got %b exp 0", bus_if.bus_req); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_txn = 0; txn_base = 0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_read();
    test_store();
    test_flush_wait();
    test_flush_req();
    test_addr_error();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
